// File: rtl/spi_apb_slave_if.sv
// APB3 register front-end for the SPI master: control/baud/status/data registers, TX hand-off,
// RX capture and interrupt. Optional macro SPI_PSLVERR_EN enables PSLVERR on bad accesses.
module spi_apb_slave_if #(
   parameter logic [7:0] CR1_RST = 8'h04,
   parameter logic [7:0] BR_RST  = 8'h00
) (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic [2:0] PADDR,
   input  logic       PWRITE,
   input  logic       PSEL,
   input  logic       PENABLE,
   input  logic [7:0] PWDATA,
   output logic [7:0] PRDATA,
   output logic       PREADY,
   output logic       PSLVERR,
   input  logic [7:0] miso_data,
   input  logic       receive_data,
   input  logic       ss,
   input  logic       tip,
   output logic [7:0] mosi_data,
   output logic       send_data,
   output logic       mstr,
   output logic       cpol,
   output logic       cpha,
   output logic       lsbfe,
   output logic       spiswai,
   output logic [2:0] sppr,
   output logic [2:0] spr,
   output logic [1:0] spi_mode,
   output logic       spi_interrupt_request
);

   typedef enum logic [1:0] {StIdle, StSetup, StEnable} apb_state_e;
   typedef enum logic [1:0] {ModeRun = 2'b00, ModeWait = 2'b01, ModeStop = 2'b10} mode_e;

   localparam logic [2:0] AddrCr1 = 3'd0;
   localparam logic [2:0] AddrCr2 = 3'd1;
   localparam logic [2:0] AddrBr  = 3'd2;
   localparam logic [2:0] AddrSr  = 3'd3;
   localparam logic [2:0] AddrDr  = 3'd5;

   apb_state_e apb_state_q, apb_state_d;
   mode_e      mode_q, mode_d;
   logic [7:0] cr1_q, cr1_d, cr2_q, cr2_d, br_q, br_d, dr_q, dr_d, mosi_q, mosi_d;
   logic       spif_q, spif_d, sptef_q, sptef_d, pending_q, pending_d, send_q, send_d;
   logic       spe, modf, wr_en, rd_en, launch, bad_access;
   logic [7:0] sr, rd_mux;

   assign spe  = cr1_q[6];
   assign modf = cr1_q[4] & cr2_q[4] & ~cr1_q[1] & ~ss;
   assign sr   = {spif_q, 1'b0, sptef_q, modf, 4'b0000};

   // Strobes are qualified by live PSEL/PENABLE so the trailing ENABLE cycle never re-fires.
   assign wr_en  = (apb_state_q == StEnable) & PSEL & PENABLE & PWRITE;
   assign rd_en  = (apb_state_q == StEnable) & PSEL & PENABLE & ~PWRITE;
   assign launch = pending_q & spe & ~tip & (mode_q != ModeStop);

`ifdef SPI_PSLVERR_EN
   assign bad_access = (PADDR == 3'd4) | (PADDR == 3'd6) | (PADDR == 3'd7) |
                       (PWRITE & (PADDR == AddrSr));
`else
   assign bad_access = 1'b0;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) apb_state_q <= StIdle;
      else          apb_state_q <= apb_state_d;
   end

   always_comb begin
      apb_state_d = apb_state_q;
      unique case (apb_state_q)
         StIdle:   if (PSEL && !PENABLE) apb_state_d = StSetup;
         StSetup:  if (!PSEL) apb_state_d = StIdle;
                   else if (PENABLE) apb_state_d = StEnable;
         StEnable: if (!PSEL) apb_state_d = StIdle;
                   else if (!PENABLE) apb_state_d = StSetup;
         default:  apb_state_d = StIdle;
      endcase
   end

   always_comb begin
      unique case (PADDR)
         AddrCr1: rd_mux = cr1_q;
         AddrCr2: rd_mux = cr2_q;
         AddrBr:  rd_mux = br_q;
         AddrSr:  rd_mux = sr;
         AddrDr:  rd_mux = dr_q;
         default: rd_mux = 8'h00;
      endcase
      PREADY  = (apb_state_q == StEnable);
      PRDATA  = (PREADY && !PWRITE) ? rd_mux : 8'h00;
      PSLVERR = PREADY & bad_access;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) mode_q <= ModeRun;
      else          mode_q <= mode_d;
   end

   always_comb begin
      mode_d = mode_q;
      unique case (mode_q)
         ModeRun:  if (!spe) mode_d = ModeWait;
         ModeWait: if (spe) mode_d = ModeRun;
                   else if (cr2_q[1]) mode_d = ModeStop;
         ModeStop: if (spe) mode_d = ModeRun;
                   else if (!cr2_q[1]) mode_d = ModeWait;
         default:  mode_d = ModeRun;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cr1_q     <= CR1_RST;
         cr2_q     <= 8'h00;
         br_q      <= BR_RST;
         dr_q      <= 8'h00;
         spif_q    <= 1'b0;
         sptef_q   <= 1'b1;
         pending_q <= 1'b0;
         mosi_q    <= 8'h00;
         send_q    <= 1'b0;
      end else begin
         cr1_q     <= cr1_d;
         cr2_q     <= cr2_d;
         br_q      <= br_d;
         dr_q      <= dr_d;
         spif_q    <= spif_d;
         sptef_q   <= sptef_d;
         pending_q <= pending_d;
         mosi_q    <= mosi_d;
         send_q    <= send_d;
      end
   end

   // Later assignments take priority: RX beats a DR read-clear, an APB DR write beats RX.
   always_comb begin
      cr1_d     = cr1_q;
      cr2_d     = cr2_q;
      br_d      = br_q;
      dr_d      = dr_q;
      spif_d    = spif_q;
      sptef_d   = sptef_q;
      pending_d = pending_q;
      mosi_d    = mosi_q;
      send_d    = launch;
      if (launch) begin
         mosi_d    = dr_q;
         pending_d = 1'b0;
         sptef_d   = 1'b1;
      end
      if (rd_en && PADDR == AddrDr) spif_d = 1'b0;
      if (receive_data) begin
         dr_d   = miso_data;
         spif_d = 1'b1;
      end
      if (wr_en) begin
         unique case (PADDR)
            AddrCr1: cr1_d = PWDATA;
            AddrCr2: cr2_d = PWDATA & 8'h1B;
            AddrBr:  br_d  = PWDATA & 8'h77;
            AddrDr: begin
               dr_d      = PWDATA;
               sptef_d   = 1'b0;
               pending_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign mosi_data = mosi_q;
   assign send_data = send_q;
   assign mstr      = cr1_q[4];
   assign cpol      = cr1_q[3];
   assign cpha      = cr1_q[2];
   assign lsbfe     = cr1_q[0];
   assign spiswai   = cr2_q[1];
   assign sppr      = br_q[6:4];
   assign spr       = br_q[2:0];
   assign spi_mode  = mode_q;
   assign spi_interrupt_request = (cr1_q[7] & (spif_q | modf)) | (cr1_q[5] & sptef_q);

endmodule

// File: tb/tb_spi_apb_slave_if.sv
// Self-checking bench for spi_apb_slave_if: directed scenarios plus randomized register traffic
// checked against a transaction-level register model.
module tb_spi_apb_slave_if;

   logic       PCLK = 1'b0;
   logic       PRESETn;
   logic [2:0] PADDR;
   logic       PWRITE, PSEL, PENABLE;
   logic [7:0] PWDATA, PRDATA;
   logic       PREADY, PSLVERR;
   logic [7:0] miso_data, mosi_data;
   logic       receive_data, ss, tip, send_data;
   logic       mstr, cpol, cpha, lsbfe, spiswai;
   logic [2:0] sppr, spr;
   logic [1:0] spi_mode;
   logic       spi_interrupt_request;

   int n_tests = 0;
   int n_fail  = 0;

   // Transaction-level model of the register file
   logic [7:0] m_cr1, m_cr2, m_br, m_dr;
   logic       m_spif, m_sptef, m_pending;

   spi_apb_slave_if dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL),
      .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .miso_data(miso_data), .receive_data(receive_data), .ss(ss), .tip(tip),
      .mosi_data(mosi_data), .send_data(send_data), .mstr(mstr), .cpol(cpol), .cpha(cpha),
      .lsbfe(lsbfe), .spiswai(spiswai), .sppr(sppr), .spr(spr), .spi_mode(spi_mode),
      .spi_interrupt_request(spi_interrupt_request)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, act, exp);
      end
   endtask

   task automatic apb(input logic wr, input logic [2:0] addr, input logic [7:0] wdata,
                      output logic [7:0] rdata, output logic err);
      bit ok = 1'b0;
      @(negedge PCLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
      @(negedge PCLK);
      PENABLE = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge PCLK);
         if (PREADY === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      rdata = PRDATA;
      err   = PSLVERR;
      if (!ok) check("pready_timeout", {7'd0, PREADY}, 8'h01);
      @(posedge PCLK);
      #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_wr(input logic [2:0] addr, input logic [7:0] wdata);
      logic [7:0] rd;
      logic       err;
      apb(1'b1, addr, wdata, rd, err);
   endtask

   task automatic apb_rd(input logic [2:0] addr, output logic [7:0] rdata);
      logic err;
      apb(1'b0, addr, 8'h00, rdata, err);
   endtask

   task automatic rx_pulse(input logic [7:0] data);
      @(negedge PCLK);
      miso_data = data; receive_data = 1'b1;
      @(negedge PCLK);
      receive_data = 1'b0;
   endtask

   task automatic count_sends(input int cycles, output int cnt, output logic [7:0] last);
      cnt = 0; last = 8'h00;
      for (int i = 0; i < cycles; i++) begin
         @(negedge PCLK);
         if (send_data === 1'b1) begin
            cnt++;
            last = mosi_data;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge PCLK);
      PRESETn = 1'b0;
      @(negedge PCLK);
      PRESETn = 1'b1;
      m_cr1 = 8'h04; m_cr2 = 8'h00; m_br = 8'h00; m_dr = 8'h00;
      m_spif = 1'b0; m_sptef = 1'b1; m_pending = 1'b0;
   endtask

   function automatic logic m_modf();
      return m_cr1[4] & m_cr2[4] & ~m_cr1[1] & ~ss;
   endfunction

   function automatic logic [7:0] m_read(input logic [2:0] addr);
      case (addr)
         3'd0:    return m_cr1;
         3'd1:    return m_cr2;
         3'd2:    return m_br;
         3'd3:    return {m_spif, 1'b0, m_sptef, m_modf(), 4'b0000};
         3'd5:    return m_dr;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic m_intr();
      return (m_cr1[7] & (m_spif | m_modf())) | (m_cr1[5] & m_sptef);
   endfunction

   function automatic logic m_err(input logic wr, input logic [2:0] addr);
`ifdef SPI_PSLVERR_EN
      return (addr == 3'd4) || (addr == 3'd6) || (addr == 3'd7) || (wr && addr == 3'd3);
`else
      return 1'b0 & wr & addr[0];
`endif
   endfunction

   initial begin
      logic [7:0] rd, mcap, d, exp_rd;
      logic       err, wr, saw_wait;
      logic [2:0] addr;
      int         cnt;

      PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 3'd0;
      PWDATA = 8'h00; miso_data = 8'h00; receive_data = 1'b0; ss = 1'b1; tip = 1'b0;
      #1 PRESETn = 1'b0;
      #2;
      check("rst_prdata", PRDATA, 8'h00);
      check("rst_pready", {7'd0, PREADY}, 8'h00);
      check("rst_pslverr", {7'd0, PSLVERR}, 8'h00);
      check("rst_cpha", {7'd0, cpha}, 8'h01);
      check("rst_mode", {6'd0, spi_mode}, 8'h00);
      check("rst_intr", {7'd0, spi_interrupt_request}, 8'h00);
      check("rst_tx", {send_data, 7'd0} | mosi_data, 8'h00);
      @(negedge PCLK);
      PRESETn = 1'b1;

      apb_rd(3'd0, rd); check("rd_cr1_rst", rd, 8'h04);
      apb_rd(3'd3, rd); check("rd_sr_rst", rd, 8'h20);

      apb_wr(3'd0, 8'h1C); apb_wr(3'd1, 8'h82); apb_wr(3'd2, 8'hC3);
      apb_rd(3'd0, rd); check("rd_cr1", rd, 8'h1C);
      apb_rd(3'd1, rd); check("rd_cr2", rd, 8'h02);
      apb_rd(3'd2, rd); check("rd_br", rd, 8'h43);
      check("cfg_bits", {mstr, cpol, cpha, lsbfe, spiswai, 3'd0}, 8'hE8);
      check("cfg_baud", {1'b0, sppr, 1'b0, spr}, 8'h43);
      check("mode_stop", {6'd0, spi_mode}, 8'h02);

      apb_wr(3'd0, 8'h5C);
      @(negedge PCLK); @(negedge PCLK);
      check("mode_run", {6'd0, spi_mode}, 8'h00);
      apb_wr(3'd0, 8'h1C);
      saw_wait = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge PCLK);
         if (spi_mode == 2'b01) saw_wait = 1'b1;
      end
      check("mode_saw_wait", {7'd0, saw_wait}, 8'h01);
      check("mode_stop2", {6'd0, spi_mode}, 8'h02);

      apb_wr(3'd1, 8'h00); apb_wr(3'd0, 8'h40);
      apb_wr(3'd5, 8'h3C);
      count_sends(6, cnt, mcap);
      check("tx_pulses", 8'(cnt), 8'h01);
      check("tx_mosi", mcap, 8'h3C);
      apb_rd(3'd3, rd); check("tx_sr", rd, 8'h20);

      tip = 1'b1;
      apb_wr(3'd5, 8'h5A);
      count_sends(5, cnt, mcap);
      check("tip_hold", 8'(cnt), 8'h00);
      apb_rd(3'd3, rd); check("tip_sr", rd, 8'h00);
      tip = 1'b0;
      count_sends(6, cnt, mcap);
      check("tip_release", 8'(cnt), 8'h01);
      check("tip_mosi", mcap, 8'h5A);

      rx_pulse(8'hA5);
      apb_rd(3'd3, rd); check("rx_sr_set", rd, 8'hA0);
      apb_rd(3'd5, rd); check("rx_dr", rd, 8'hA5);
      apb_rd(3'd3, rd); check("rx_sr_clr", rd, 8'h20);

      apb_wr(3'd0, 8'h80);
      check("irq_idle", {7'd0, spi_interrupt_request}, 8'h00);
      rx_pulse(8'hFF);
      @(negedge PCLK);
      check("irq_set", {7'd0, spi_interrupt_request}, 8'h01);
      apb_rd(3'd5, rd); check("irq_dr", rd, 8'hFF);
      check("irq_clr", {7'd0, spi_interrupt_request}, 8'h00);

      apb(1'b1, 3'd6, 8'hFF, rd, err); check("unm_wr_err", {7'd0, err}, {7'd0, m_err(1'b1, 3'd6)});
      apb(1'b0, 3'd6, 8'h00, rd, err); check("unm_rd", rd, 8'h00);
      check("unm_rd_err", {7'd0, err}, {7'd0, m_err(1'b0, 3'd6)});
      apb(1'b1, 3'd3, 8'hFF, rd, err); check("sr_wr_err", {7'd0, err}, {7'd0, m_err(1'b1, 3'd3)});
      apb_rd(3'd3, rd); check("sr_ro", rd, 8'h20);

      apb_wr(3'd0, 8'h40);
      tip = 1'b1;
      apb_wr(3'd5, 8'h77);
      @(negedge PCLK);
      #2 PRESETn = 1'b0;
      #1;
      check("arst_tx", {send_data, 7'd0} | mosi_data, 8'h00);
      check("arst_cfg", {mstr, cpol, cpha, lsbfe, spiswai, 1'b0, spi_mode}, 8'h20);
      @(negedge PCLK);
      PRESETn = 1'b1;
      tip = 1'b0;
      apb_wr(3'd0, 8'h40);
      count_sends(6, cnt, mcap);
      check("arst_no_tx", 8'(cnt), 8'h00);

      // Randomized register traffic; tip held high so no transfer launches
      do_reset();
      tip = 1'b1;
      for (int it = 0; it < 150; it++) begin
         if ($urandom_range(0, 5) == 0) begin
            d = 8'($urandom);
            rx_pulse(d);
            m_dr = d; m_spif = 1'b1;
         end
         ss   = 1'($urandom_range(0, 1));
         addr = 3'($urandom_range(0, 7));
         wr   = 1'($urandom_range(0, 1));
         d    = 8'($urandom);
         exp_rd = wr ? 8'h00 : m_read(addr);
         apb(wr, addr, d, rd, err);
         check("rand_rd", rd, exp_rd);
         check("rand_err", {7'd0, err}, {7'd0, m_err(wr, addr)});
         if (wr) begin
            case (addr)
               3'd0: m_cr1 = d;
               3'd1: m_cr2 = d & 8'h1B;
               3'd2: m_br = d & 8'h77;
               3'd5: begin m_dr = d; m_sptef = 1'b0; m_pending = 1'b1; end
               default: ;
            endcase
         end else if (addr == 3'd5) begin
            m_spif = 1'b0;
         end
         check("rand_intr", {7'd0, spi_interrupt_request}, {7'd0, m_intr()});
         check("rand_cfg", {send_data, mstr, cpol, cpha, lsbfe, spiswai, 2'd0},
               {1'b0, m_cr1[4], m_cr1[3], m_cr1[2], m_cr1[0], m_cr2[1], 2'd0});
         check("rand_baud", {1'b0, sppr, 1'b0, spr}, m_br);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
